// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl upload path.
package ioctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACTIVE,
    ST_FETCH
  } upload_state_t;

  // Byte returned for reads past the end of the upload.
  localparam logic [7:0] PAD_BYTE     = 8'hFF;
  // Byte returned when core memory never acknowledges a read.
  localparam logic [7:0] TIMEOUT_BYTE = 8'hEE;

endpackage

// File: rtl/ioctl_upload_server.sv
// Serves hps_io upload reads from core memory: requests an upload, then
// answers each ioctl_rd with a fetched byte, a pad byte or a timeout byte.
module ioctl_upload_server
  import ioctl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              upload_start,
  input  logic [ADDR_W:0]   upload_size,
  output logic              upload_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  upload_state_t     state, state_n;
  logic [ADDR_W:0]   size_q, size_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [7:0]        din_n;
  logic              wait_n, mem_rd_n, err_n;
  logic [ADDR_W-1:0] mem_addr_n;

  assign busy = (state != ST_IDLE);

  // State and all outputs are registered; reset clears everything.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      size_q     <= '0;
      cnt        <= '0;
      upload_req <= 1'b0;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      size_q     <= size_n;
      cnt        <= cnt_n;
      upload_req <= (state_n == ST_REQ);
      ioctl_din  <= din_n;
      ioctl_wait <= wait_n;
      mem_addr   <= mem_addr_n;
      mem_rd     <= mem_rd_n;
      err        <= err_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    size_n     = size_q;
    cnt_n      = cnt;
    din_n      = ioctl_din;
    wait_n     = ioctl_wait;
    mem_addr_n = mem_addr;
    mem_rd_n   = mem_rd;
    err_n      = err;
    case (state)
      ST_IDLE: begin
        if (upload_start) begin
          size_n  = upload_size;
          err_n   = 1'b0;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ioctl_upload && (ioctl_index == UPLOAD_INDEX)) state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // ACTIVE is only entered with ioctl_upload high, so a low level here
        // is the falling edge that ends the transfer.
        if (!ioctl_upload) begin
          state_n  = ST_IDLE;
          mem_rd_n = 1'b0;
          wait_n   = 1'b0;
        end else if (ioctl_rd) begin
          if (ioctl_addr < 25'(size_q)) begin
            mem_addr_n = ioctl_addr[ADDR_W-1:0];
            mem_rd_n   = 1'b1;
            wait_n     = 1'b1;
            cnt_n      = '0;
            state_n    = ST_FETCH;
          end else begin
            din_n = PAD_BYTE;
          end
        end
      end
      ST_FETCH: begin
        if (!ioctl_upload) begin
          state_n  = ST_IDLE;
          mem_rd_n = 1'b0;
          wait_n   = 1'b0;
        end else begin
          if (ioctl_rd) err_n = 1'b1;
          if (mem_ack) begin
            din_n    = mem_data;
            mem_rd_n = 1'b0;
            wait_n   = 1'b0;
            state_n  = ST_ACTIVE;
          end else if (cnt == CNT_LAST) begin
            din_n    = TIMEOUT_BYTE;
            err_n    = 1'b1;
            mem_rd_n = 1'b0;
            wait_n   = 1'b0;
            state_n  = ST_ACTIVE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Directed self-checking bench for ioctl_upload_server.
module tb_ioctl_upload_server;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned TMO    = 8;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              upload_start;
  logic [ADDR_W:0]   upload_size;
  logic              upload_req;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic              ioctl_rd;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              mem_ack;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  logic auto_ack  = 1'b1;
  logic force_ack = 1'b0;

  ioctl_upload_server #(
    .ADDR_W(ADDR_W),
    .UPLOAD_INDEX(8'd2),
    .TIMEOUT(TMO)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .upload_start(upload_start),
    .upload_size(upload_size),
    .upload_req(upload_req),
    .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .mem_ack(mem_ack),
    .busy(busy),
    .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  // Memory model: byte at address a is A0+a; acks mid-cycle while mem_rd is high.
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk_sys);
      mem_ack  = (auto_ack && mem_rd) || force_ack;
      mem_data = 8'hA0 + 8'(mem_addr[3:0]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start(input logic [ADDR_W:0] size);
    upload_start = 1'b1;
    upload_size  = size;
    tick();
    upload_start = 1'b0;
  endtask

  task automatic rd_mem(input logic [24:0] addr, input logic [7:0] exp);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    check("fetch_mem_rd", 32'(mem_rd), 32'd1);
    check("fetch_wait", 32'(ioctl_wait), 32'd1);
    check("fetch_addr", 32'(mem_addr), 32'(addr[ADDR_W-1:0]));
    tick();
    check("rd_data", 32'(ioctl_din), 32'(exp));
    check("rd_wait_low", 32'(ioctl_wait), 32'd0);
    check("rd_mem_rd_low", 32'(mem_rd), 32'd0);
  endtask

  task automatic rd_pad(input logic [24:0] addr);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    check("pad_data", 32'(ioctl_din), 32'hFF);
    check("pad_wait", 32'(ioctl_wait), 32'd0);
    check("pad_no_mem_rd", 32'(mem_rd), 32'd0);
    tick();
    check("pad_no_mem_rd2", 32'(mem_rd), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    upload_start = 1'b0;
    upload_size  = '0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_addr   = '0;
    ioctl_rd     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_upload_req", 32'(upload_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_din", 32'(ioctl_din), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);

    // Request phase, with the wrong index first.
    start(15'd4);
    check("req_upload_req", 32'(upload_req), 32'd1);
    check("req_busy", 32'(busy), 32'd1);
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd1;
    tick();
    tick();
    check("req_wrong_index", 32'(upload_req), 32'd1);
    ioctl_index = 8'd2;
    tick();
    check("active_upload_req", 32'(upload_req), 32'd0);
    check("active_busy", 32'(busy), 32'd1);

    // In-range reads, then first out-of-range address.
    for (int unsigned a = 0; a < 4; a++) rd_mem(25'(a), 8'hA0 + 8'(a));
    rd_pad(25'd4);
    tick();
    check("din_hold", 32'(ioctl_din), 32'hFF);

    // Withheld ack runs into the timeout.
    auto_ack   = 1'b0;
    ioctl_addr = 25'd1;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    repeat (TMO - 1) tick();
    check("tmo_still_wait", 32'(ioctl_wait), 32'd1);
    tick();
    check("tmo_din", 32'(ioctl_din), 32'hEE);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_wait", 32'(ioctl_wait), 32'd0);
    check("tmo_mem_rd", 32'(mem_rd), 32'd0);
    auto_ack = 1'b1;
    rd_mem(25'd2, 8'hA2);
    check("err_sticky", 32'(err), 32'd1);

    // Upload drops mid-fetch; a stray ack afterwards changes nothing.
    auto_ack   = 1'b0;
    ioctl_addr = 25'd3;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_mem_rd", 32'(mem_rd), 32'd0);
    check("drop_wait", 32'(ioctl_wait), 32'd0);
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    check("stray_ack_din", 32'(ioctl_din), 32'hA2);
    check("stray_ack_busy", 32'(busy), 32'd0);

    // Reset in the middle of a fetch.
    start(15'd4);
    check("start_clears_err", 32'(err), 32'd0);
    ioctl_upload = 1'b1;
    tick();
    ioctl_addr = 25'd0;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("pre_rst_mem_rd", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("frst_mem_rd", 32'(mem_rd), 32'd0);
    check("frst_wait", 32'(ioctl_wait), 32'd0);
    check("frst_din", 32'(ioctl_din), 32'd0);
    check("frst_busy", 32'(busy), 32'd0);
    check("frst_mem_addr", 32'(mem_addr), 32'd0);
    check("frst_upload_req", 32'(upload_req), 32'd0);
    auto_ack = 1'b1;
    start(15'd2);
    check("restart_req", 32'(upload_req), 32'd1);
    tick();
    rd_mem(25'd1, 8'hA1);
    rd_pad(25'd2);

    // A read during FETCH flags an error but the fetch still completes.
    auto_ack   = 1'b0;
    ioctl_addr = 25'd0;
    ioctl_rd   = 1'b1;
    tick();
    tick();
    ioctl_rd = 1'b0;
    check("dbl_rd_err", 32'(err), 32'd1);
    check("dbl_rd_wait", 32'(ioctl_wait), 32'd1);
    auto_ack = 1'b1;
    tick();
    check("dbl_rd_data", 32'(ioctl_din), 32'hA0);
    check("dbl_rd_wait_low", 32'(ioctl_wait), 32'd0);

    // Zero-size upload pads everything; upload_start while busy is ignored.
    ioctl_upload = 1'b0;
    tick();
    start(15'd0);
    ioctl_upload = 1'b1;
    tick();
    rd_pad(25'd0);
    start(15'd4);
    check("start_ignored_req", 32'(upload_req), 32'd0);
    rd_pad(25'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
